// File: rtl/if_pc_fetch.sv
// Instruction-fetch stage: PC register, req/ack fetch to instruction memory, single-entry IF/ID slot.
// Define IF_MISALIGN_CHECK_EN to trap on a misaligned PC instead of forcing word alignment.
module if_pc_fetch #(
  parameter int                  PC_WIDTH    = 9,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc_next_i,
  input  logic                   redirect_i,
  output logic [PC_WIDTH-1:0]    pc_plus4_o,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   ifid_valid_o,
  output logic [PC_WIDTH-1:0]    ifid_pc_o,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o,
`ifdef IF_MISALIGN_CHECK_EN
  output logic                   misalign_o,
`endif
  input  logic                   ifid_ready_i
);

`ifdef IF_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_DROP, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_DROP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;
  logic [PC_WIDTH-1:0]    slot_pc_q, slot_pc_d;
  logic [INSTR_WIDTH-1:0] slot_instr_q, slot_instr_d;
  logic                   slot_free;
`ifdef IF_MISALIGN_CHECK_EN
  logic                   misalign_q, misalign_d;
`endif

  function automatic logic [PC_WIDTH-1:0] load_pc(input logic [PC_WIDTH-1:0] a);
`ifdef IF_MISALIGN_CHECK_EN
    return a;
`else
    return a & ~PC_WIDTH'(3);
`endif
  endfunction

  assign pc_plus4_o   = pc_q + PC_WIDTH'(4);
  assign imem_addr_o  = pc_q;
  assign imem_req_o   = req_q;
  assign ifid_valid_o = valid_q;
  assign ifid_pc_o    = slot_pc_q;
  assign ifid_instr_o = slot_instr_q;
`ifdef IF_MISALIGN_CHECK_EN
  assign misalign_o   = misalign_q;
`endif

  // A fetch may only be issued when the slot will be empty by the time its ack lands.
  assign slot_free = !valid_q || ifid_ready_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    valid_d      = valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
`ifdef IF_MISALIGN_CHECK_EN
    misalign_d   = misalign_q;
`endif

    if (valid_q && ifid_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        // A redirect here suppresses issue so the stale PC is never fetched.
        if (redirect_i) begin
          pc_d = load_pc(pc_next_i);
        end
`ifdef IF_MISALIGN_CHECK_EN
        else if (pc_q[1:0] != 2'b00) begin
          state_d    = S_TRAP;
          misalign_d = 1'b1;
        end
`endif
        else if (slot_free) begin
          req_d   = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (redirect_i) begin
          pc_d    = load_pc(pc_next_i);
          req_d   = 1'b0;
          state_d = imem_ack_i ? S_IDLE : S_DROP;
        end else if (imem_ack_i) begin
          valid_d      = 1'b1;
          slot_pc_d    = pc_q;
          slot_instr_d = imem_rdata_i;
          pc_d         = load_pc(pc_next_i);
          req_d        = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_DROP: begin
        if (redirect_i) begin
          pc_d = load_pc(pc_next_i);
        end
        if (imem_ack_i) begin
          state_d = S_IDLE;
        end
      end
`ifdef IF_MISALIGN_CHECK_EN
      S_TRAP: begin
        if (redirect_i) begin
          pc_d       = load_pc(pc_next_i);
          misalign_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Redirect flushes the slot, overriding both drain and fill.
    if (redirect_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      slot_pc_q    <= '0;
      slot_instr_q <= '0;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
`ifdef IF_MISALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

endmodule
